rr_mux_stream: RTL
==================

Name: rr_mux_stream

Overview:
- Parametrised N-channel, W-bit streaming multiplexer with a registered output stage and valid/ready handshakes on every input and on the output.
- Successor to the single-bit 2:1 mux primitive: it generalises width and channel count, adds a run-time fixed/round-robin select mode, and adds an optional bitwise inversion of the selected word.
- Sits between several producer streams and one consumer, and is used as the lab's generic channel combiner.

Parameters:
- W, 8, data width per channel (>=1).
- N, 4, number of input channels (>=2).
- SW, $clog2(N), channel index width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-channel valid; bit i is channel i.
- in_data  input  N*W  channel i data at bits [i*W +: W].
- in_ready  output  N  per-channel ready; one-hot or zero.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SW  channel used when mode=0.
- inv  input  1  1 = output stores bitwise NOT of the selected word.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered word.
- out_chan  output  SW  channel index the word came from.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (async assert, sync-safe release): out_valid=0, out_data=0, out_chan=0, rr_ptr=N-1. The first round-robin search therefore starts at channel 0.
- can_load = !out_valid || out_ready.
- Grant in mode 0: grant = sel if in_valid[sel]. Otherwise there is no grant. A sel >= N gives no grant.
- Grant in mode 1: grant = first i with in_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... mod N. The scan wraps from N-1 to 0. With no valid input there is no grant.
- in_ready[grant] = can_load. All other in_ready bits are 0. in_ready is combinational from in_valid, mode, sel, out_valid, out_ready, rr_ptr.
- Transfer on a channel = in_valid[i] && in_ready[i]. On that edge:
  - out_data <= inv ? ~in_data[i] : in_data[i]
  - out_chan <= i
  - out_valid <= 1
  - rr_ptr <= i (rr_ptr updates only on a transfer and only in mode 1)
- If out_valid && out_ready and there is no transfer: out_valid <= 0. out_data and out_chan keep their old values.
- Simultaneous drain and load: the new word replaces the old one in the same edge. The output is bubble-free, 1 word/cycle sustained.
- Stall (out_valid && !out_ready): out_data and out_chan are held stable, all in_ready=0, rr_ptr is unchanged.
- Latency is 1 cycle from input transfer to out_valid.
- inv, mode and sel are sampled only at the transfer edge. Changing them does not alter a word already held in the register.
- Fairness in mode 1: with all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,... with no repeats.
- Reset asserted mid-transfer: state clears immediately and the in-flight word is dropped. After release the block behaves as after power-up.
- Inputs may drop in_valid without a transfer; the block places no hold requirement on producers.

Test Plan:
- Reset, then W=8, N=4, mode=0, sel=2, inv=0, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_chan=2.
- Same as above with inv=1 -> out_data=8'h5A. This is the constant-0/1 NOT check generalised to W bits.
- mode=1, in_valid=4'b1111 constant, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle after the first.
- mode=1, in_valid=4'b1010 -> grants 1,3,1,3. Then set in_valid=4'b0001 -> the next grant is 0 (wrap from rr_ptr=3).
- Output stall: load ch0=8'h11, then hold out_ready=0 for 3 cycles with ch1 valid -> out_data stays 11, in_ready=0. Raise out_ready -> ch1 loads on that same edge, with no bubble.
- Assert rst_n=0 while out_valid=1 -> out_valid, out_data and out_chan go to 0 without a clock edge. After release with mode=1 and all valid, the first grant is ch0.

Source files
------------

// File: rtl/rr_mux_stream_if.sv
// Stream bundle between N producers, the channel combiner and one consumer.
interface rr_mux_stream_if #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
);
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic           inv;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_ready;

  // Producer/consumer side: drives stream inputs and control, observes outputs.
  modport master (
    output in_valid, in_data, mode, sel, inv, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  // Combiner side.
  modport slave (
    input  in_valid, in_data, mode, sel, inv, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/rr_mux_stream.sv
// N-channel W-bit streaming mux with fixed/round-robin select, optional
// inversion and a single bubble-free registered output stage.
module rr_mux_stream #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_mux_stream_if.slave s
);
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
  // Valid/ready vectors are padded to a power of two so any sel value indexes safely.
  localparam int unsigned NP = 1 << SW;

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] grant;
  logic [SW-1:0] idx;
  logic          grant_vld;
  logic          can_load;
  logic          xfer;
  logic [W-1:0]  grant_data;
  logic [NP-1:0] valid_ext;
  logic [NP-1:0] ready_ext;

  // Grant selection: fixed channel or round-robin scan starting after rr_ptr.
  always_comb begin
    valid_ext = NP'(s.in_valid);
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    if (!s.mode) begin
      grant     = s.sel;
      grant_vld = valid_ext[s.sel];
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        idx = SW'((int'(rr_ptr) + int'(k)) % int'(N));
        if (!grant_vld && valid_ext[idx]) begin
          grant     = idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

  // Handshake: only the granted channel sees ready, and only when the register can take a word.
  always_comb begin
    can_load  = !s.out_valid || s.out_ready;
    xfer      = grant_vld && can_load;
    ready_ext = '0;
    if (xfer) begin
      ready_ext[grant] = 1'b1;
    end
    s.in_ready = N'(ready_ext);
  end

  // Data path mux for the granted channel.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        grant_data = s.in_data[i*W +: W];
      end
    end
  end

  // Output register and round-robin pointer; load and drain may share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_chan  <= '0;
      rr_ptr      <= SW'(N - 1);
    end else if (xfer) begin
      s.out_valid <= 1'b1;
      s.out_data  <= s.inv ? ~grant_data : grant_data;
      s.out_chan  <= grant;
      if (s.mode) begin
        rr_ptr <= grant;
      end
    end else if (s.out_ready) begin
      s.out_valid <= 1'b0;
    end
  end
endmodule
